// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage_pkg
// Description : Shared FSM encoding and lane-geometry helpers for the MEM stage
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_stage_pkg;

    localparam int c_XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int lanes_of(input int xlen);
        return xlen / 8;
    endfunction

    function automatic int lsb_of(input int xlen);
        return $clog2(xlen / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage_if
// Description : Valid/ready data-memory port between the MEM stage and memory
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if #(
    parameter int XLEN = 32
) ();
    localparam int LANES = XLEN / 8;

    logic             dmem_req_valid;
    logic             dmem_req_ready;
    logic             dmem_req_we;
    logic [XLEN-1:0]  dmem_req_addr;
    logic [XLEN-1:0]  dmem_req_wdata;
    logic [LANES-1:0] dmem_req_wstrb;
    logic             dmem_resp_valid;
    logic [XLEN-1:0]  dmem_resp_rdata;

    modport master (
        output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage_byte_lane.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_lane
// Description : Store-data replication / strobe generation and load lane extract
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_lane
    import mem_access_stage_pkg::*;
#(
    parameter  int XLEN  = c_XLEN_DEFAULT,
    localparam int LANES = lanes_of(XLEN),
    localparam int LSB   = lsb_of(XLEN)
) (
    input  logic [LSB-1:0]   lane,
    input  logic             byt,
    input  logic [XLEN-1:0]  st_data,
    input  logic [XLEN-1:0]  ld_word,
    output logic [XLEN-1:0]  wdata,
    output logic [LANES-1:0] wstrb,
    output logic [XLEN-1:0]  ld_data
);
    localparam logic [LANES-1:0] c_LANE0 = LANES'(1);

    logic [7:0] w_ld_byte;

    assign w_ld_byte = ld_word[{lane, 3'b000} +: 8];
    assign wdata     = byt ? {LANES{st_data[7:0]}} : st_data;
    assign wstrb     = byt ? (c_LANE0 << lane) : {LANES{1'b1}};
    assign ld_data   = byt ? {{(XLEN-8){1'b0}}, w_ld_byte} : ld_word;

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM pipeline stage - dmem load/store sequencing, stall, MEM/WB reg
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int XLEN = c_XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] MEM_alu_out,
    input  logic [XLEN-1:0] MEM_b2,
    input  logic [4:0]      MEM_rd,
    input  logic            MEM_we,
    input  logic            MEM_ld,
    input  logic            MEM_str,
    input  logic            MEM_byt,
    input  logic [XLEN-1:0] MEM_link_addr,
    input  logic            MEM_link_we,
    output logic            MEM_stall,
    mem_access_stage_if.master dmem,
    output logic [XLEN-1:0] WB_data,
    output logic [4:0]      WB_rd,
    output logic            WB_we
);
    localparam int LANES = lanes_of(XLEN);
    localparam int LSB   = lsb_of(XLEN);

    state_t           r_state;
    logic [XLEN-1:0]  r_hold;
    logic             w_is_mem;
    logic             w_store;
    logic [XLEN-1:0]  w_wdata;
    logic [LANES-1:0] w_wstrb;
    logic [XLEN-1:0]  w_ld_data;
    logic [XLEN-1:0]  w_wb_data;

    assign w_is_mem = MEM_ld | MEM_str;
    assign w_store  = MEM_str & ~MEM_ld;

    // Stall depends only on state and the op, never on memory inputs.
    assign MEM_stall = ((r_state == ST_IDLE) && w_is_mem) ||
                       (r_state == ST_REQ) || (r_state == ST_RESP);

    mem_byte_lane #(.XLEN(XLEN)) u_lane (
        .lane    (MEM_alu_out[LSB-1:0]),
        .byt     (MEM_byt),
        .st_data (MEM_b2),
        .ld_word (r_hold),
        .wdata   (w_wdata),
        .wstrb   (w_wstrb),
        .ld_data (w_ld_data)
    );

    assign dmem.dmem_req_valid = (r_state == ST_REQ);
    assign dmem.dmem_req_we    = w_store;
    assign dmem.dmem_req_addr  = {MEM_alu_out[XLEN-1:LSB], {LSB{1'b0}}};
    assign dmem.dmem_req_wdata = w_wdata;
    assign dmem.dmem_req_wstrb = w_store ? w_wstrb : {LANES{1'b0}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_is_mem) r_state <= ST_REQ;
                ST_REQ: begin
                    if (dmem.dmem_req_ready) r_state <= MEM_ld ? ST_RESP : ST_DONE;
                end
                ST_RESP: begin
                    if (dmem.dmem_resp_valid) begin
                        r_hold  <= dmem.dmem_resp_rdata;
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_wb_data = MEM_link_we ? MEM_link_addr :
                       MEM_ld      ? w_ld_data     : MEM_alu_out;

    // While stalled a bubble is written so the held op is not retired twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            WB_data <= '0;
            WB_rd   <= '0;
            WB_we   <= 1'b0;
        end else if (!MEM_stall) begin
            WB_data <= w_wb_data;
            WB_rd   <= MEM_rd;
            WB_we   <= MEM_we | MEM_link_we;
        end else begin
            WB_we   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Randomized self-checking bench with a transaction-level model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_out, b2, link_addr;
    logic [4:0]  rd;
    logic        we, ld, str, byt, link_we;
    logic        stall;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_access_stage_if #(.XLEN(32)) dmem ();

    mem_access_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .MEM_alu_out(alu_out), .MEM_b2(b2), .MEM_rd(rd),
        .MEM_we(we), .MEM_ld(ld), .MEM_str(str), .MEM_byt(byt),
        .MEM_link_addr(link_addr), .MEM_link_we(link_we), .MEM_stall(stall),
        .dmem(dmem), .WB_data(wb_data), .WB_rd(wb_rd), .WB_we(wb_we)
    );

    // Reference model: transaction-level expectations
    function automatic int exp_stalls(input logic l, s, input int rw, sw);
        if (l) return 3 + rw + sw;
        if (s) return 2 + rw;
        return 0;
    endfunction

    function automatic logic [31:0] exp_wb(input logic l, lk, bt, input logic [31:0] a,
                                           input logic [31:0] la, rdata);
        if (lk) return la;
        if (l)  return bt ? ((rdata >> (8 * a[1:0])) & 32'hFF) : rdata;
        return a;
    endfunction

    // Drives one EX/MEM op, plays memory with given wait cycles, returns observations.
    task automatic run_op(input logic o_ld, o_str, o_byt, o_we, o_link,
                          input logic [31:0] o_addr, o_b2, o_la, input logic [4:0] o_rd,
                          input int rw, sw, input logic [31:0] rdata,
                          output int stalls, output int n_req,
                          output logic [31:0] h_addr, h_wdata, output logic [3:0] h_wstrb,
                          output logic h_we, output logic stable, output logic timed_out);
        int phase, cnt;
        logic first;
        logic [31:0] f_addr, f_wdata;
        @(negedge clk);
        ld = o_ld; str = o_str; byt = o_byt; we = o_we; link_we = o_link;
        alu_out = o_addr; b2 = o_b2; link_addr = o_la; rd = o_rd;
        stalls = 0; n_req = 0; stable = 1'b1; timed_out = 1'b1;
        phase = 0; cnt = 0; first = 1'b1;
        h_addr = '0; h_wdata = '0; h_wstrb = '0; h_we = 1'b0; f_addr = '0; f_wdata = '0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            dmem.dmem_req_ready = 1'b0;
            dmem.dmem_resp_valid = 1'b0;
            if (phase == 1) begin
                if (cnt == sw) begin
                    dmem.dmem_resp_valid = 1'b1;
                    dmem.dmem_resp_rdata = rdata;
                    phase = 2;
                end else cnt++;
            end
            #1;
            if (dmem.dmem_req_valid && phase == 0) begin
                if (first) begin
                    f_addr = dmem.dmem_req_addr; f_wdata = dmem.dmem_req_wdata; first = 1'b0;
                end else if (f_addr !== dmem.dmem_req_addr || f_wdata !== dmem.dmem_req_wdata)
                    stable = 1'b0;
                if (cnt == rw) begin
                    dmem.dmem_req_ready = 1'b1;
                    n_req++;
                    h_addr = dmem.dmem_req_addr; h_wdata = dmem.dmem_req_wdata;
                    h_wstrb = dmem.dmem_req_wstrb; h_we = dmem.dmem_req_we;
                    phase = o_ld ? 1 : 2;
                    cnt = 0;
                end else cnt++;
            end
            if (!stall) begin
                timed_out = 1'b0;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        ld = 0; str = 0; we = 0; link_we = 0; byt = 0;
        dmem.dmem_req_ready = 1'b0; dmem.dmem_resp_valid = 1'b0;
        if (timed_out) begin
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
        end
    endtask

    int          st, nr;
    logic [31:0] ha, hw;
    logic [3:0]  hs;
    logic        hwe, stb, to;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || dmem.dmem_req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl stall=%b req_valid=%b expected 0/0", stall, dmem.dmem_req_valid);
        end
        checks++;
        if ({wb_data, wb_rd, wb_we} !== 38'd0) begin
            errors++; $display("FAIL reset_wb data=%h rd=%0d we=%b expected zeros", wb_data, wb_rd, wb_we);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        run_op(0, 0, 0, 1, 0, 32'h1234, 0, 0, 5'd5, 0, 0, 0, st, nr, ha, hw, hs, hwe, stb, to);
        checks++;
        if (st !== 0 || nr !== 0) begin
            errors++; $display("FAIL alu_stall stalls=%0d reqs=%0d expected 0/0", st, nr);
        end
        checks++;
        if (wb_data !== 32'h1234 || wb_rd !== 5'd5 || wb_we !== 1'b1) begin
            errors++; $display("FAIL alu_wb data=%h rd=%0d we=%b expected 1234/5/1", wb_data, wb_rd, wb_we);
        end
    endtask

    task automatic test_word_store();
        run_op(0, 1, 0, 0, 0, 32'h100, 32'hDEADBEEF, 0, 5'd3, 0, 0, 0, st, nr, ha, hw, hs, hwe, stb, to);
        checks++;
        if (ha !== 32'h100 || hw !== 32'hDEADBEEF || hs !== 4'hF || hwe !== 1'b1) begin
            errors++; $display("FAIL wstore_req addr=%h wdata=%h wstrb=%h we=%b expected 100/deadbeef/f/1", ha, hw, hs, hwe);
        end
        checks++;
        if (st !== 2 || wb_we !== 1'b0) begin
            errors++; $display("FAIL wstore_stall stalls=%0d wb_we=%b expected 2/0", st, wb_we);
        end
    endtask

    task automatic test_byte_load();
        run_op(1, 0, 1, 1, 0, 32'h103, 0, 0, 5'd7, 2, 3, 32'hAABBCCDD, st, nr, ha, hw, hs, hwe, stb, to);
        checks++;
        if (ha !== 32'h100 || hwe !== 1'b0 || stb !== 1'b1) begin
            errors++; $display("FAIL bload_req addr=%h we=%b stable=%b expected 100/0/1", ha, hwe, stb);
        end
        checks++;
        if (st !== 8) begin
            errors++; $display("FAIL bload_stall stalls=%0d expected 8", st);
        end
        checks++;
        if (wb_data !== 32'hAA || wb_rd !== 5'd7 || wb_we !== 1'b1) begin
            errors++; $display("FAIL bload_wb data=%h rd=%0d we=%b expected aa/7/1", wb_data, wb_rd, wb_we);
        end
    endtask

    task automatic test_byte_store();
        run_op(0, 1, 1, 0, 0, 32'h201, 32'h0000005A, 0, 5'd1, 1, 0, 0, st, nr, ha, hw, hs, hwe, stb, to);
        checks++;
        if (ha !== 32'h200 || hw !== 32'h5A5A5A5A || hs !== 4'b0010 || st !== 3) begin
            errors++; $display("FAIL bstore_req addr=%h wdata=%h wstrb=%b stalls=%0d expected 200/5a5a5a5a/0010/3", ha, hw, hs, st);
        end
    endtask

    task automatic test_link_spurious();
        @(negedge clk);
        dmem.dmem_resp_valid = 1'b1;
        dmem.dmem_resp_rdata = 32'h11111111;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL spurious_stall stall=%b expected 0", stall);
        end
        @(negedge clk);
        dmem.dmem_resp_valid = 1'b0;
        run_op(0, 0, 0, 0, 1, 32'h999, 0, 32'h40, 5'd31, 0, 0, 0, st, nr, ha, hw, hs, hwe, stb, to);
        checks++;
        if (wb_data !== 32'h40 || wb_we !== 1'b1 || st !== 0) begin
            errors++; $display("FAIL link_wb data=%h we=%b stalls=%0d expected 40/1/0", wb_data, wb_we, st);
        end
        run_op(1, 1, 0, 1, 0, 32'h302, 32'hFFFF, 0, 5'd9, 0, 0, 32'h22223333, st, nr, ha, hw, hs, hwe, stb, to);
        checks++;
        if (wb_data !== 32'h22223333 || hwe !== 1'b0 || ha !== 32'h300 || st !== 3) begin
            errors++; $display("FAIL ldprio_load data=%h req_we=%b addr=%h stalls=%0d expected 22223333/0/300/3", wb_data, hwe, ha, st);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        ld = 1; alu_out = 32'h10; we = 1; rd = 5'd4;
        n = 0;
        while (!dmem.dmem_req_valid && n < 20) begin
            @(negedge clk); n++;
        end
        dmem.dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem.dmem_req_ready = 1'b0;
        checks++;
        if (stall !== 1'b1 || dmem.dmem_req_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_resp stall=%b req_valid=%b expected 1/0", stall, dmem.dmem_req_valid);
        end
        rst = 1'b1; ld = 0; we = 0;
        @(posedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || dmem.dmem_req_valid !== 1'b0 || wb_we !== 1'b0) begin
            errors++; $display("FAIL rstmid_after stall=%b req_valid=%b wb_we=%b expected 0/0/0", stall, dmem.dmem_req_valid, wb_we);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int total;
        logic [31:0] d1;
        total = 0;
        run_op(1, 0, 0, 1, 0, 32'h400, 0, 0, 5'd10, 0, 1, 32'hCAFEF00D, st, nr, ha, hw, hs, hwe, stb, to);
        total += nr; d1 = wb_data;
        checks++;
        if (d1 !== 32'hCAFEF00D || wb_rd !== 5'd10 || wb_we !== 1'b1) begin
            errors++; $display("FAIL b2b_first data=%h rd=%0d we=%b expected cafef00d/10/1", d1, wb_rd, wb_we);
        end
        run_op(1, 0, 1, 1, 0, 32'h402, 0, 0, 5'd11, 1, 0, 32'h00770000, st, nr, ha, hw, hs, hwe, stb, to);
        total += nr;
        checks++;
        if (wb_data !== 32'h77 || wb_rd !== 5'd11 || wb_we !== 1'b1 || total !== 2) begin
            errors++; $display("FAIL b2b_second data=%h rd=%0d we=%b reqs=%0d expected 77/11/1/2", wb_data, wb_rd, wb_we, total);
        end
    endtask

    task automatic test_random();
        logic l, s, bt, w, lk;
        logic [31:0] a, d, la, rdata, ea, ewd;
        logic [3:0]  ews;
        logic [4:0]  r;
        int rw, sw, kind;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 4);
            l  = (kind == 1) || (kind == 4);
            s  = (kind == 2) || (kind == 4);
            lk = (kind == 3) || ($urandom_range(0, 7) == 0);
            bt = $urandom_range(0, 1);
            w  = $urandom_range(0, 1);
            a  = $urandom; d = $urandom; la = $urandom; rdata = $urandom;
            r  = 5'($urandom_range(0, 31));
            rw = $urandom_range(0, 3); sw = $urandom_range(0, 3);
            run_op(l, s, bt, w, lk, a, d, la, r, rw, sw, rdata, st, nr, ha, hw, hs, hwe, stb, to);
            checks++;
            if (to !== 1'b0 || st !== exp_stalls(l, s, rw, sw) || nr !== ((l | s) ? 1 : 0)) begin
                errors++; $display("FAIL rand_timing[%0d] timeout=%b stalls=%0d reqs=%0d expected 0/%0d/%0d",
                                   i, to, st, nr, exp_stalls(l, s, rw, sw), (l | s) ? 1 : 0);
            end
            checks++;
            if (wb_data !== exp_wb(l, lk, bt, a, la, rdata) || wb_rd !== r || wb_we !== (w | lk)) begin
                errors++; $display("FAIL rand_wb[%0d] data=%h rd=%0d we=%b expected %h/%0d/%b",
                                   i, wb_data, wb_rd, wb_we, exp_wb(l, lk, bt, a, la, rdata), r, w | lk);
            end
            if (s && !l) begin
                ea  = a & ~32'h3;
                ewd = bt ? {4{d[7:0]}} : d;
                ews = bt ? (4'b0001 << a[1:0]) : 4'hF;
                checks++;
                if (ha !== ea || hw !== ewd || hs !== ews || hwe !== 1'b1 || stb !== 1'b1) begin
                    errors++; $display("FAIL rand_store[%0d] addr=%h wdata=%h wstrb=%b we=%b stable=%b expected %h/%h/%b/1/1",
                                       i, ha, hw, hs, hwe, stb, ea, ewd, ews);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        alu_out = '0; b2 = '0; link_addr = '0; rd = '0;
        we = 0; ld = 0; str = 0; byt = 0; link_we = 0;
        dmem.dmem_req_ready = 1'b0;
        dmem.dmem_resp_valid = 1'b0;
        dmem.dmem_resp_rdata = '0;
        test_reset();
        test_alu();
        test_word_store();
        test_byte_load();
        test_byte_store();
        test_link_spurious();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
